// File: rtl/alu16_pipe_if.sv
// ---------------------------------------------------------------------------
// alu16_pipe_if
//   Bundles the handshake and data signals of the pipelined Hack ALU.
//
//   Signals:
//     in_valid / in_ready   operand beat handshake (producer -> ALU)
//     x, y                  WIDTH-bit operands
//     ctrl                  {zx, nx, zy, ny, f, no}
//     out_valid / out_ready result handshake (ALU -> consumer)
//     out                   WIDTH-bit result word
//     zr, ng                zero / negative flags of out
//     ov                    signed overflow flag (only with ALU16_OVF_EN)
//
//   Modports:
//     master  the side that feeds operands and consumes results
//     slave   the ALU itself
//
//   Optional feature macro: ALU16_OVF_EN (adds the ov signal).
// ---------------------------------------------------------------------------
interface alu16_pipe_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [5:0]       ctrl;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             zr;
    logic             ng;
`ifdef ALU16_OVF_EN
    logic             ov;

    modport master (
        output in_valid, x, y, ctrl, out_ready,
        input  in_ready, out_valid, out, zr, ng, ov
    );

    modport slave (
        input  in_valid, x, y, ctrl, out_ready,
        output in_ready, out_valid, out, zr, ng, ov
    );
`else
    modport master (
        output in_valid, x, y, ctrl, out_ready,
        input  in_ready, out_valid, out, zr, ng
    );

    modport slave (
        input  in_valid, x, y, ctrl, out_ready,
        output in_ready, out_valid, out, zr, ng
    );
`endif
endinterface

// File: rtl/alu16_pipe.sv
// ---------------------------------------------------------------------------
// alu16_pipe
//   Two-stage pipelined Hack-style ALU with valid/ready flow control.
//   Stage 1 applies the zero/negate pre-processing to x and y; stage 2
//   performs AND (f=0) or ADD (f=1), the optional output negation, and
//   registers the result together with its zr/ng flags.
//
//   Ports:
//     clk    rising-edge clock
//     reset  synchronous, active-high reset
//     bus    alu16_pipe_if.slave: in_valid/in_ready, x, y, ctrl,
//            out_valid/out_ready, out, zr, ng (and ov when enabled)
//
//   Optional feature macro: ALU16_OVF_EN
//     When defined, a registered signed-overflow flag ov is produced for
//     the add path (always 0 for the AND path).
// ---------------------------------------------------------------------------
module alu16_pipe #(
    parameter int WIDTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    alu16_pipe_if.slave bus
);
    localparam int MSB = WIDTH - 1;

    logic             s1_valid;
    logic             s2_valid;
    logic             s1_adv;
    logic             s2_adv;
    logic             in_xfer;

    logic [WIDTH-1:0] xz;
    logic [WIDTH-1:0] yz;
    logic [WIDTH-1:0] xp_d;
    logic [WIDTH-1:0] yp_d;
    logic [WIDTH-1:0] xp_q;
    logic [WIDTH-1:0] yp_q;
    logic             f_q;
    logic             no_q;

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] out_q;
    logic             zr_q;
    logic             ng_q;

    // Stage 2 can take a new beat when it is empty or its result is leaving;
    // in_ready is forced low while reset is held so nothing is accepted then.
    assign s2_adv       = !s2_valid || bus.out_ready;
    assign s1_adv       = s1_valid && s2_adv;
    assign bus.in_ready = !reset && (!s1_valid || s2_adv);
    assign in_xfer      = bus.in_valid && bus.in_ready;

    // Operand pre-processing: zero first, then optionally invert.
    assign xz   = bus.ctrl[5] ? '0 : bus.x;
    assign xp_d = bus.ctrl[4] ? ~xz : xz;
    assign yz   = bus.ctrl[3] ? '0 : bus.y;
    assign yp_d = bus.ctrl[2] ? ~yz : yz;

    // Stage 1 occupancy: a new beat takes priority over draining, which
    // covers the same-edge accept-and-advance case.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
        end else if (in_xfer) begin
            s1_valid <= 1'b1;
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    // Stage 1 data is qualified by s1_valid, so it carries no reset.
    always_ff @(posedge clk) begin
        if (in_xfer) begin
            xp_q <= xp_d;
            yp_q <= yp_d;
            f_q  <= bus.ctrl[1];
            no_q <= bus.ctrl[0];
        end
    end

    // Function select and output negation.
    assign sum = xp_q + yp_q;
    assign r   = f_q ? sum : (xp_q & yp_q);
    assign res = no_q ? ~r : r;

`ifdef ALU16_OVF_EN
    logic ov_d;
    logic ov_q;

    // Signed overflow: operands share a sign that the sum does not.
    assign ov_d = f_q && (xp_q[MSB] == yp_q[MSB]) && (sum[MSB] != xp_q[MSB]);
`endif

    // Stage 2: when stage 1 is empty only the valid bit drops, the data
    // registers keep their last value.
    always_ff @(posedge clk) begin
        if (reset) begin
            s2_valid <= 1'b0;
            out_q    <= '0;
            zr_q     <= 1'b0;
            ng_q     <= 1'b0;
`ifdef ALU16_OVF_EN
            ov_q     <= 1'b0;
`endif
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_q <= res;
                zr_q  <= (res == '0);
                ng_q  <= res[MSB];
`ifdef ALU16_OVF_EN
                ov_q  <= ov_d;
`endif
            end
        end
    end

    assign bus.out_valid = s2_valid;
    assign bus.out       = out_q;
    assign bus.zr        = zr_q;
    assign bus.ng        = ng_q;
`ifdef ALU16_OVF_EN
    assign bus.ov        = ov_q;
`endif

endmodule

// File: tb/tb_alu16_pipe.sv
// ---------------------------------------------------------------------------
// tb_alu16_pipe
//   Directed testbench for alu16_pipe. Inputs are driven and outputs sampled
//   on the falling clock edge. Build with ALU16_OVF_EN defined to also
//   exercise the overflow flag.
// ---------------------------------------------------------------------------
module tb_alu16_pipe;
    localparam int WIDTH = 16;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    alu16_pipe_if #(.WIDTH(WIDTH)) bus ();

    alu16_pipe #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // 10 ns clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point shared by all checks.
    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Present one operand beat.
    task automatic applyStimulus(input logic [15:0] xv, input logic [15:0] yv, input logic [5:0] cv);
        bus.in_valid = 1'b1;
        bus.x        = xv;
        bus.y        = yv;
        bus.ctrl     = cv;
    endtask

    // Compare the visible result beat against expected values.
    task automatic checkOutput(input string tag, input logic [15:0] eo, input logic ez, input logic en);
        checkVal({tag, ".out_valid"}, {31'd0, bus.out_valid}, 32'd1);
        checkVal({tag, ".out"},       {16'd0, bus.out},       {16'd0, eo});
        checkVal({tag, ".zr"},        {31'd0, bus.zr},        {31'd0, ez});
        checkVal({tag, ".ng"},        {31'd0, bus.ng},        {31'd0, en});
    endtask

    // One isolated beat: accept, confirm nothing after one cycle, result
    // after two. Returns at the falling edge where the result is visible.
    task automatic runSingle(input string tag, input logic [15:0] xv, input logic [15:0] yv,
                             input logic [5:0] cv, input logic [15:0] eo, input logic ez,
                             input logic en);
        applyStimulus(xv, yv, cv);
        #1;
        checkVal({tag, ".in_ready"}, {31'd0, bus.in_ready}, 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        checkVal({tag, ".early"}, {31'd0, bus.out_valid}, 32'd0);
        @(negedge clk);
        checkOutput(tag, eo, ez, en);
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.x         = '0;
        bus.y         = '0;
        bus.ctrl      = '0;
        bus.out_ready = 1'b1;

        // Reset state
        @(negedge clk);
        checkVal("rst.in_ready", {31'd0, bus.in_ready}, 32'd0);
        @(negedge clk);
        checkVal("rst.out_valid", {31'd0, bus.out_valid}, 32'd0);
        checkVal("rst.out", {16'd0, bus.out}, 32'd0);
        checkVal("rst.zr", {31'd0, bus.zr}, 32'd0);
        checkVal("rst.ng", {31'd0, bus.ng}, 32'd0);
        reset = 1'b0;
        #1;
        checkVal("rel.in_ready", {31'd0, bus.in_ready}, 32'd1);
        @(negedge clk);

        // Add and subtract
        runSingle("add", 16'd5, 16'd3, 6'b000010, 16'd8, 1'b0, 1'b0);
        @(negedge clk);
        runSingle("sub", 16'd5, 16'd3, 6'b010011, 16'd2, 1'b0, 1'b0);
        @(negedge clk);

        // Constants and AND
        runSingle("zero", 16'h1234, 16'h5678, 6'b101010, 16'h0000, 1'b1, 1'b0);
        @(negedge clk);
        runSingle("minus1", 16'h1234, 16'h5678, 6'b111010, 16'hFFFF, 1'b0, 1'b1);
        @(negedge clk);
        runSingle("and", 16'h00FF, 16'hF0F0, 6'b000000, 16'h00F0, 1'b0, 1'b0);
        @(negedge clk);

        // Back-to-back: x=0..7, y=1, add; results 1..8 on consecutive cycles
        for (int k = 0; k <= 10; k++) begin
            if (k >= 2 && k <= 9) begin
                checkOutput($sformatf("b2b%0d", k - 2), 16'(k - 1), 1'b0, 1'b0);
            end
            if (k < 8) begin
                applyStimulus(16'(k), 16'd1, 6'b000010);
                #1;
                checkVal($sformatf("b2b.in_ready%0d", k), {31'd0, bus.in_ready}, 32'd1);
            end else begin
                bus.in_valid = 1'b0;
            end
            if (k == 10) begin
                checkVal("b2b.bubble", {31'd0, bus.out_valid}, 32'd0);
            end
            @(negedge clk);
        end

        // Backpressure: two beats fill the pipe, the third waits
        bus.out_ready = 1'b0;
        applyStimulus(16'd10, 16'd0, 6'b000010);
        #1;
        checkVal("bp.rdy0", {31'd0, bus.in_ready}, 32'd1);
        @(negedge clk);
        applyStimulus(16'd20, 16'd0, 6'b000010);
        #1;
        checkVal("bp.rdy1", {31'd0, bus.in_ready}, 32'd1);
        @(negedge clk);
        applyStimulus(16'd30, 16'd0, 6'b000010);
        #1;
        checkVal("bp.full", {31'd0, bus.in_ready}, 32'd0);
        checkOutput("bp.hold0", 16'd10, 1'b0, 1'b0);
        @(negedge clk);
        checkVal("bp.full2", {31'd0, bus.in_ready}, 32'd0);
        checkOutput("bp.hold1", 16'd10, 1'b0, 1'b0);
        bus.out_ready = 1'b1;
        #1;
        checkVal("bp.resume", {31'd0, bus.in_ready}, 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        checkOutput("bp.o20", 16'd20, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("bp.o30", 16'd30, 1'b0, 1'b0);
        @(negedge clk);
        checkVal("bp.empty", {31'd0, bus.out_valid}, 32'd0);

        // Reset mid-operation discards in-flight beats
        bus.out_ready = 1'b0;
        applyStimulus(16'd100, 16'd0, 6'b000010);
        @(negedge clk);
        applyStimulus(16'hFF00, 16'd0, 6'b000010);
        @(negedge clk);
        bus.in_valid = 1'b0;
        reset        = 1'b1;
        @(negedge clk);
        checkVal("mrst.out_valid", {31'd0, bus.out_valid}, 32'd0);
        checkVal("mrst.out", {16'd0, bus.out}, 32'd0);
        checkVal("mrst.zr", {31'd0, bus.zr}, 32'd0);
        checkVal("mrst.ng", {31'd0, bus.ng}, 32'd0);
        checkVal("mrst.in_ready", {31'd0, bus.in_ready}, 32'd0);
        reset         = 1'b0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkVal($sformatf("mrst.stale%0d", k), {31'd0, bus.out_valid}, 32'd0);
        end
        @(negedge clk);

        // Overflow vectors (out/flags always checked, ov only when enabled)
        runSingle("ovf.pos", 16'h7FFF, 16'h0001, 6'b000010, 16'h8000, 1'b0, 1'b1);
`ifdef ALU16_OVF_EN
        checkVal("ovf.pos.ov", {31'd0, bus.ov}, 32'd1);
`endif
        @(negedge clk);
        runSingle("ovf.none", 16'h0001, 16'h0001, 6'b000010, 16'h0002, 1'b0, 1'b0);
`ifdef ALU16_OVF_EN
        checkVal("ovf.none.ov", {31'd0, bus.ov}, 32'd0);
`endif
        @(negedge clk);
        runSingle("ovf.and", 16'h0001, 16'h0001, 6'b000000, 16'h0001, 1'b0, 1'b0);
`ifdef ALU16_OVF_EN
        checkVal("ovf.and.ov", {31'd0, bus.ov}, 32'd0);
`endif
        @(negedge clk);
        runSingle("ovf.andx", 16'h7FFF, 16'h0001, 6'b000000, 16'h0001, 1'b0, 1'b0);
`ifdef ALU16_OVF_EN
        checkVal("ovf.andx.ov", {31'd0, bus.ov}, 32'd0);
`endif
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
